shift_issue_queue: RTL and testbench

- Execute-stage front end for the combinational shifter in the miniRISC datapath.
- Accepts decoded shift micro-ops from decode over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives the shifter from the FIFO head, resolves the shift amount (immediate or register), and registers the result plus destination register index for writeback over a second valid/ready handshake.

---
 rtl/shift_issue_queue_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/shift_issue_queue.sv | 99 +++++++++
 tb/tb_shift_issue_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_issue_queue_pkg.sv
// shift_issue_queue_pkg: shared shift-type codes, amount-select codes and the queued entry layout
package shift_issue_queue_pkg;

    localparam logic [1:0] SH_LL = 2'b00;
    localparam logic [1:0] SH_LA = 2'b01;
    localparam logic [1:0] SH_RL = 2'b10;
    localparam logic [1:0] SH_RA = 2'b11;

    localparam logic AMT_IMM = 1'b0;
    localparam logic AMT_REG = 1'b1;

    // One buffered micro-op; the shift amount is already resolved when it is queued
    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  shType;
        logic        enbl;
        logic [4:0]  amt;
        logic [4:0]  rd;
    } shiftEntry_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fallthrough read port and synchronous clear
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    assign rdData = mem[rdPtr];
    assign full   = count == (PTR_W+1)'(DEPTH);
    assign empty  = count == '0;

    // Pointers wrap naturally at the power-of-two depth; count carries one extra bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop) rdPtr <= rdPtr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Storage is not reset; contents are only observed through valid occupancy
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/shift_issue_queue.sv
// shift_issue_queue: buffers shift micro-ops, drives the external shifter from the queue head and registers results for writeback
module shift_issue_queue
    import shift_issue_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [1:0]  in_type,
    input  logic        in_enbl,
    input  logic        in_amt_sel,
    input  logic [4:0]  in_imm_amt,
    input  logic [31:0] in_reg_amt,
    input  logic [4:0]  in_rd,
    output logic [31:0] sh_a,
    output logic [1:0]  sh_type,
    output logic [4:0]  sh_amt,
    output logic        sh_enbl,
    input  logic [31:0] sh_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    shiftEntry_t      pushEntry;
    shiftEntry_t      head;
    logic             push;
    logic             capture;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   fifoCount;
    logic             unusedRegAmt;

    // Only the low five bits of a register amount can encode a 32-bit shift
    assign unusedRegAmt = ^in_reg_amt[31:5];

    assign pushEntry = '{
        a:      in_a,
        shType: in_type,
        enbl:   in_enbl,
        amt:    (in_amt_sel == AMT_REG) ? in_reg_amt[4:0] : in_imm_amt,
        rd:     in_rd
    };

    // Readiness looks only at occupancy so out_ready never reaches in_ready combinationally
    assign in_ready = fifoCount != (PTR_W+1)'(DEPTH);
    assign push     = in_valid && in_ready;
    assign capture  = !empty && (!out_valid || out_ready);

    sync_fifo #(
        .WIDTH ($bits(shiftEntry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .push   (push),
        .pop    (capture),
        .wrData (pushEntry),
        .rdData (head),
        .full   (full),
        .empty  (empty),
        .count  (fifoCount)
    );

    assign sh_a    = empty ? '0 : head.a;
    assign sh_type = empty ? SH_LL : head.shType;
    assign sh_amt  = empty ? '0 : head.amt;
    assign sh_enbl = empty ? 1'b0 : head.enbl;

    // Output register: flush invalidates, capture loads the head result, an accepted result with nothing behind drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            out_result <= sh_result;
            out_rd     <= head.rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    noPushWhenFull: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    noPopWhenEmpty: assert property (@(posedge clk) disable iff (!rst_n) !(capture && empty));
    holdStable: assert property (@(posedge clk) disable iff (!rst_n) (out_valid && !out_ready) |=> $stable(out_result));

endmodule

// File: tb/tb_shift_issue_queue.sv
// tb_shift_issue_queue: randomized and directed checks of the shift issue queue against a queue-based reference model
module tb_shift_issue_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [1:0]  in_type;
    logic        in_enbl;
    logic        in_amt_sel;
    logic [4:0]  in_imm_amt;
    logic [31:0] in_reg_amt;
    logic [4:0]  in_rd;
    logic [31:0] sh_a;
    logic [1:0]  sh_type;
    logic [4:0]  sh_amt;
    logic        sh_enbl;
    logic [31:0] sh_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  amt;
        logic [31:0] res;
        logic [4:0]  rd;
    } op_t;

    op_t         q[$];
    logic        mValid;
    logic [31:0] mRes;
    logic [4:0]  mRd;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] shiftRef(input logic [31:0] a, input logic [1:0] t, input logic en, input logic [4:0] amt);
        if (!en) return a;
        case (t)
            2'b10:   return a >> amt;
            2'b11:   return $unsigned($signed(a) >>> amt);
            default: return a << amt;
        endcase
    endfunction

    // Stand-in for the external combinational shifter
    assign sh_result = shiftRef(sh_a, sh_type, sh_enbl, sh_amt);

    shift_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_type    (in_type),
        .in_enbl    (in_enbl),
        .in_amt_sel (in_amt_sel),
        .in_imm_amt (in_imm_amt),
        .in_reg_amt (in_reg_amt),
        .in_rd      (in_rd),
        .sh_a       (sh_a),
        .sh_type    (sh_type),
        .sh_amt     (sh_amt),
        .sh_enbl    (sh_enbl),
        .sh_result  (sh_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clearModel();
        q.delete();
        mValid = 1'b0;
    endtask

    // Reference behaviour at a clock edge, using the inputs presented during the cycle
    task automatic modelEdge();
        op_t  o;
        logic pushOk;
        pushOk = in_valid && (q.size() != DEPTH);
        if (flush) begin
            clearModel();
            return;
        end
        if (q.size() > 0 && (!mValid || out_ready)) begin
            mValid = 1'b1;
            mRes   = q[0].res;
            mRd    = q[0].rd;
            void'(q.pop_front());
        end else if (out_ready) begin
            mValid = 1'b0;
        end
        if (pushOk) begin
            o.a   = in_a;
            o.amt = in_amt_sel ? in_reg_amt[4:0] : in_imm_amt;
            o.res = shiftRef(in_a, in_type, in_enbl, o.amt);
            o.rd  = in_rd;
            q.push_back(o);
        end
    endtask

    task automatic compareAll();
        check("in_ready", in_ready, q.size() != DEPTH);
        check("out_valid", out_valid, mValid);
        if (mValid) begin
            check("out_result", out_result, mRes);
            check("out_rd", out_rd, mRd);
        end
        check("sh_a", sh_a, q.size() > 0 ? q[0].a : 32'h0);
        check("sh_amt", sh_amt, q.size() > 0 ? q[0].amt : 5'h0);
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareAll();
    endtask

    task automatic setOp(input logic [31:0] a, input logic [1:0] t, input logic en, input logic sel,
                         input logic [4:0] imm, input logic [31:0] regAmt, input logic [4:0] rd);
        in_a       = a;
        in_type    = t;
        in_enbl    = en;
        in_amt_sel = sel;
        in_imm_amt = imm;
        in_reg_amt = regAmt;
        in_rd      = rd;
        in_valid   = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        setOp('0, 2'b00, 1'b0, 1'b0, '0, '0, '0);
        in_valid = 1'b0;
        clearModel();
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", out_rd, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Reset while ops are queued and in flight
        setOp(32'h0000_00AA, 2'b00, 1'b1, 1'b0, 5'd1, '0, 5'd9);
        cycle();
        cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        clearModel();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_sh_a", sh_a, 0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) cycle();

        // Arithmetic right shift by immediate
        setOp(32'h8000_0001, 2'b11, 1'b1, 1'b0, 5'd4, 32'h0, 5'd7);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("ra_valid", out_valid, 1);
        check("ra_result", out_result, 32'hF800_0000);
        check("ra_rd", out_rd, 7);
        cycle();

        // Register amount with junk upper bits
        setOp(32'h0000_00F0, 2'b00, 1'b1, 1'b1, 5'd0, 32'hFFFF_FF24, 5'd3);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("reg_result", out_result, 32'h0000_0F00);
        check("reg_rd", out_rd, 3);
        cycle();

        // Back-pressure fills the queue behind a held output, then drains in order
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setOp(32'h1, 2'b00, 1'b1, 1'b0, 5'(i + 1), '0, 5'(10 + i));
            cycle();
        end
        in_valid = 1'b0;
        check("full_in_ready", in_ready, 0);
        repeat (3) begin
            cycle();
            check("hold_result", out_result, 32'h2);
        end
        out_ready = 1'b1;
        cycle();
        check("drain1", out_result, 32'h4);
        check("drain1_rd", out_rd, 11);
        cycle();
        check("drain2", out_result, 32'h8);
        check("drain2_rd", out_rd, 12);
        cycle();
        check("drain_empty", out_valid, 0);

        // Pass-through at full rate
        setOp(32'h1234_5678, 2'b10, 1'b0, 1'b0, 5'd9, '0, 5'd5);
        cycle();
        repeat (6) begin
            cycle();
            check("bypass_valid", out_valid, 1);
            check("bypass_result", out_result, 32'h1234_5678);
        end
        in_valid = 1'b0;
        repeat (2) cycle();

        // Flush with a full queue, a valid output and a same-cycle push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setOp(32'hF0F0_0000 + 32'(i), 2'b01, 1'b1, 1'b0, 5'(i), '0, 5'(20 + i));
            cycle();
        end
        flush = 1'b1;
        setOp(32'hDEAD_BEEF, 2'b00, 1'b1, 1'b0, 5'd1, '0, 5'd30);
        cycle();
        check("flush_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            cycle();
            check("flush_no_op", out_valid, 0);
        end

        // Random traffic
        repeat (400) begin
            setOp($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom), $urandom, 5'($urandom));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = $urandom_range(0, 19) == 0;
            cycle();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
